uart_mmio: RTL and testbench
============================

# uart_mmio

Memory-mapped front end for the UART controller, sitting between the MIPS data bus and the UART controller's byte interface. Buffers outgoing bytes in a TX FIFO and drains them into the controller with the `din`/`din_rdy` strobe. Captures each `dout`/`dout_rdy` byte into an RX FIFO. Exposes data, status and control registers to the CPU.

## Interface
Parameters:
- `FIFO_AW`, default 3: FIFO address width; each FIFO holds 2^FIFO_AW bytes (8 by default).

Ports:
- `clk`  in  1: system clock.
- `rst`  in  1: reset, asynchronous, active-high.
- `addr`  in  2: word select, bus address bits [3:2]. 0 = DATA, 1 = STATUS, 2 = CTRL, 3 = reserved.
- `we`  in  1: bus write strobe, one cycle per access.
- `re`  in  1: bus read strobe, one cycle per access.
- `wdata`  in  32: bus write data.
- `rdata`  out  32: registered bus read data.
- `din`  out  8: byte to the controller's transmitter.
- `din_rdy`  out  1: one-cycle strobe; `din` is valid in the same cycle.
- `tx_rdy`  in  1: controller transmitter idle and able to accept a byte.
- `dout`  in  8: byte received by the controller.
- `dout_rdy`  in  1: one-cycle strobe; `dout` is valid in the same cycle.
- `irq`  out  1: level interrupt to the CPU.

## Operation
- **DATA write:** pushes `wdata[7:0]` into the TX FIFO.
  - If the TX FIFO is full, the byte is dropped and sticky `tx_ovr` is set.
- **DATA read:** returns `{24'b0, rx_head}` and pops the RX FIFO.
  - If the RX FIFO is empty, returns 0 and nothing is popped.
- **STATUS read**, bit assignment:
  - [0] `rx_avail` (RX FIFO not empty)
  - [1] `rx_full`
  - [2] `tx_empty`
  - [3] `tx_full`
  - [4] `rx_ovr`
  - [5] `tx_ovr`
  - [31:6] read as 0.
- **STATUS write:** a 1 in bit 4 clears `rx_ovr`; a 1 in bit 5 clears `tx_ovr`. All other bits are ignored.
- **CTRL:** see Configuration. The reserved address reads 0 and ignores writes.
- **RX capture:** on `dout_rdy`, `dout` is pushed into the RX FIFO.
  - If the RX FIFO is full, the byte is dropped and `rx_ovr` is set.
  - If a pop happens in the same cycle, the push succeeds even when the FIFO was full.
- **TX FIFO:** a push and a pop in the same cycle both succeed.
- **TX drain FSM:**
  - `T_IDLE`: go to `T_SEND` when `tx_rdy` = 1 and the TX FIFO is not empty.
  - `T_SEND`: drive `din_rdy` = 1 and `din` = FIFO head, pop the FIFO, go to `T_BUSY`.
  - `T_BUSY`: wait for `tx_rdy` = 0, then go to `T_WAIT`.
  - `T_WAIT`: wait for `tx_rdy` = 1, then go to `T_IDLE`.
- **FIFO pointers:** FIFO_AW+1 bits wide and wrap modulo 2^(FIFO_AW+1).
  - Empty: pointers are equal.
  - Full: the MSBs differ and the low bits are equal.
- **`we` and `re` in the same cycle:** the write is performed and the read is ignored (`rdata` holds its value).

## Timing
- **Reset values:**
  - Outputs: `rdata` = 0, `din` = 0, `din_rdy` = 0, `irq` = 0.
  - State: FSM in `T_IDLE`, both FIFOs empty, `rx_ovr` = `tx_ovr` = 0, CTRL = 0.
  - Reset mid-transfer aborts the FSM and discards all FIFO contents.
- **Read latency:** `rdata` is valid the cycle after `re` and holds until the next read. A pop takes effect at the same edge.
- **Write visibility:** a write is visible in STATUS on the next cycle.
- **TX latency:** a DATA write to an empty TX FIFO with `tx_rdy` = 1 gives `din_rdy` high 2 cycles after `we`.
  - Edge 1 pushes the byte; the FSM sees the FIFO non-empty and enters `T_SEND`; `din_rdy` rises.
- **Back-to-back bytes:** successive `din_rdy` pulses are separated by at least one low-then-high cycle of `tx_rdy`.
- **RX latency:** a byte strobed by `dout_rdy` at edge N is readable by a DATA read issued after edge N; `rx_avail` = 1 from cycle N+1.

## Configuration
- Macro: `UART_MMIO_IRQ_EN`.
- **Defined:**
  - CTRL is read/write; bit 0 = `rx_ie`, bit 1 = `tx_ie`.
  - `irq` is registered: `irq` = (`rx_ie` & `rx_avail`) | (`tx_ie` & `tx_empty`).
  - `irq` updates one cycle after its sources change.
- **Undefined:** CTRL reads 0 and ignores writes; `irq` is tied to 0.

## Test plan
- **Reset:** assert `rst` asynchronously mid-`T_BUSY` with 3 bytes queued → `din_rdy` = 0 immediately; STATUS reads 0x04 after reset.
- **TX path:** write DATA 0x41, 0x42, 0x43 with `tx_rdy` modelled as busy for 10 cycles after each strobe → exactly three `din_rdy` pulses carrying 0x41, 0x42, 0x43 in order; STATUS bit 2 = 1 afterwards.
- **TX overflow:** write 9 bytes with `tx_rdy` held at 0 → bytes 1 to 8 queued; STATUS reads 0x28; write STATUS 0x20 → STATUS reads 0x08.
- **RX path:** strobe `dout_rdy` with 0x5A then 0xA5 → STATUS bit 0 = 1; DATA reads return 0x5A then 0xA5; a third read returns 0 and STATUS bit 0 = 0.
- **RX overflow with concurrent pop:**
  - 8 strobes then a 9th → 9th byte dropped, `rx_ovr` = 1.
  - A 10th strobe in the same cycle as a DATA read → byte accepted, `rx_full` stays 1.
- **IRQ** (`UART_MMIO_IRQ_EN` defined): write CTRL 0x1, strobe 0x33 → `irq` = 1; DATA read → `irq` = 0 one cycle after the pop. Write CTRL 0x2 with the TX FIFO empty → `irq` = 1.

Source files
------------

// File: rtl/uart_mmio_if.sv
// uart_mmio_if: CPU data-bus and UART byte-interface signals of uart_mmio.
// master = CPU bus plus UART controller side, slave = uart_mmio.
interface uart_mmio_if;
  logic [1:0]  addr;
  logic        we;
  logic        re;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [7:0]  din;
  logic        din_rdy;
  logic        tx_rdy;
  logic [7:0]  dout;
  logic        dout_rdy;
  logic        irq;

  modport master (
    output addr, we, re, wdata, tx_rdy, dout, dout_rdy,
    input  rdata, din, din_rdy, irq
  );

  modport slave (
    input  addr, we, re, wdata, tx_rdy, dout, dout_rdy,
    output rdata, din, din_rdy, irq
  );
endinterface

// File: rtl/uart_mmio.sv
// uart_mmio: memory-mapped front end for the UART controller.
// TX FIFO drained into the controller through a small handshake FSM, RX FIFO
// filled from dout/dout_rdy, DATA/STATUS/CTRL registers on the CPU bus.
// Optional feature macro UART_MMIO_IRQ_EN: when defined, CTRL holds rx_ie/tx_ie
// and irq is a registered level interrupt; otherwise CTRL reads 0 and irq is 0.
module uart_mmio #(
  parameter int FIFO_AW = 3
) (
  input  logic      clk,
  input  logic      rst,
  uart_mmio_if.slave bus
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] PTR_ONE = 1;

  localparam logic [1:0] A_DATA   = 2'd0;
  localparam logic [1:0] A_STATUS = 2'd1;
  localparam logic [1:0] A_CTRL   = 2'd2;

  typedef enum logic [1:0] {
    T_IDLE = 2'd0,
    T_SEND = 2'd1,
    T_BUSY = 2'd2,
    T_WAIT = 2'd3
  } tx_state_t;

  tx_state_t        tx_state;

  logic [7:0]       tx_mem [DEPTH];
  logic [7:0]       rx_mem [DEPTH];
  logic [FIFO_AW:0] tx_wp, tx_rp;
  logic [FIFO_AW:0] rx_wp, rx_rp;

  logic             tx_empty, tx_full;
  logic             rx_empty, rx_full;
  logic [7:0]       tx_head, rx_head;

  logic             rx_ovr, tx_ovr;
  logic [31:0]      rdata_q;
  logic [7:0]       din_q;
  logic             din_rdy_q;
  logic [31:0]      status_word;
  logic [31:0]      ctrl_word;

  logic             wr_data, wr_status, rd_any, rd_data;
  logic             tx_pop, tx_push;
  logic             rx_pop, rx_push;

  // Upper write-data bits carry nothing for this block.
  logic             unused_wdata;
  assign unused_wdata = ^bus.wdata[31:8];

  // FIFO flags: pointers carry one extra wrap bit.
  assign tx_empty = (tx_wp == tx_rp);
  assign tx_full  = (tx_wp[FIFO_AW] != tx_rp[FIFO_AW]) &&
                    (tx_wp[FIFO_AW-1:0] == tx_rp[FIFO_AW-1:0]);
  assign rx_empty = (rx_wp == rx_rp);
  assign rx_full  = (rx_wp[FIFO_AW] != rx_rp[FIFO_AW]) &&
                    (rx_wp[FIFO_AW-1:0] == rx_rp[FIFO_AW-1:0]);

  assign tx_head = tx_mem[tx_rp[FIFO_AW-1:0]];
  assign rx_head = rx_mem[rx_rp[FIFO_AW-1:0]];

  // A write wins over a simultaneous read; the read is then dropped.
  assign wr_data   = bus.we && (bus.addr == A_DATA);
  assign wr_status = bus.we && (bus.addr == A_STATUS);
  assign rd_any    = bus.re && !bus.we;
  assign rd_data   = rd_any && (bus.addr == A_DATA);

  // The head byte is latched into din and popped on the edge that enters
  // T_SEND, so din/din_rdy come straight from flops during T_SEND.
  assign tx_pop  = (tx_state == T_IDLE) && bus.tx_rdy && !tx_empty;
  assign tx_push = wr_data && (!tx_full || tx_pop);

  // A same-cycle pop frees a slot, so a push into a full RX FIFO still lands.
  assign rx_pop  = rd_data && !rx_empty;
  assign rx_push = bus.dout_rdy && (!rx_full || rx_pop);

  assign status_word = {26'd0, tx_ovr, rx_ovr, tx_full, tx_empty, rx_full, !rx_empty};

`ifdef UART_MMIO_IRQ_EN
  logic [1:0] ctrl;
  logic       irq_q;

  assign ctrl_word = {30'd0, ctrl};

  // CTRL register: bit 0 rx_ie, bit 1 tx_ie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl <= 2'b00;
    end else if (bus.we && (bus.addr == A_CTRL)) begin
      ctrl <= bus.wdata[1:0];
    end
  end

  // Registered interrupt level, one cycle behind its sources.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= (ctrl[0] && !rx_empty) || (ctrl[1] && tx_empty);
    end
  end

  assign bus.irq = irq_q;
`else
  assign ctrl_word = 32'd0;
  assign bus.irq   = 1'b0;
`endif

  // FIFO storage; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (tx_push) begin
      tx_mem[tx_wp[FIFO_AW-1:0]] <= bus.wdata[7:0];
    end
    if (rx_push) begin
      rx_mem[rx_wp[FIFO_AW-1:0]] <= bus.dout;
    end
  end

  // FIFO pointers; reset empties both FIFOs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_wp <= '0;
      tx_rp <= '0;
      rx_wp <= '0;
      rx_rp <= '0;
    end else begin
      if (tx_push) tx_wp <= tx_wp + PTR_ONE;
      if (tx_pop)  tx_rp <= tx_rp + PTR_ONE;
      if (rx_push) rx_wp <= rx_wp + PTR_ONE;
      if (rx_pop)  rx_rp <= rx_rp + PTR_ONE;
    end
  end

  // Sticky overflow flags; a new overflow outranks a clear in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_ovr <= 1'b0;
      tx_ovr <= 1'b0;
    end else begin
      if (bus.dout_rdy && !rx_push) begin
        rx_ovr <= 1'b1;
      end else if (wr_status && bus.wdata[4]) begin
        rx_ovr <= 1'b0;
      end
      if (wr_data && !tx_push) begin
        tx_ovr <= 1'b1;
      end else if (wr_status && bus.wdata[5]) begin
        tx_ovr <= 1'b0;
      end
    end
  end

  // Registered read data, held until the next accepted read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= 32'd0;
    end else if (rd_any) begin
      case (bus.addr)
        A_DATA:   rdata_q <= rx_empty ? 32'd0 : {24'd0, rx_head};
        A_STATUS: rdata_q <= status_word;
        A_CTRL:   rdata_q <= ctrl_word;
        default:  rdata_q <= 32'd0;
      endcase
    end
  end

  // TX drain FSM: one strobe per byte, then a full low-high cycle of tx_rdy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state  <= T_IDLE;
      din_q     <= 8'd0;
      din_rdy_q <= 1'b0;
    end else begin
      case (tx_state)
        T_IDLE: begin
          din_rdy_q <= 1'b0;
          if (tx_pop) begin
            din_q     <= tx_head;
            din_rdy_q <= 1'b1;
            tx_state  <= T_SEND;
          end
        end
        T_SEND: begin
          din_rdy_q <= 1'b0;
          tx_state  <= T_BUSY;
        end
        T_BUSY: begin
          din_rdy_q <= 1'b0;
          if (!bus.tx_rdy) tx_state <= T_WAIT;
        end
        T_WAIT: begin
          din_rdy_q <= 1'b0;
          if (bus.tx_rdy) tx_state <= T_IDLE;
        end
        default: begin
          din_rdy_q <= 1'b0;
          tx_state  <= T_IDLE;
        end
      endcase
    end
  end

  assign bus.rdata   = rdata_q;
  assign bus.din     = din_q;
  assign bus.din_rdy = din_rdy_q;

endmodule

// File: tb/tb_uart_mmio.sv
// tb_uart_mmio: scoreboard bench for uart_mmio with a queue-based reference model.
module tb_uart_mmio;
  localparam int AW    = 3;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic rst;

  uart_mmio_if bus();

  uart_mmio #(.FIFO_AW(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [7:0]  tx_q[$];
  logic [7:0]  rx_q[$];
  logic [7:0]  din_exp[$];
  logic [31:0] rd_exp[$];
  bit          m_rx_ovr;
  bit          m_tx_ovr;
`ifdef UART_MMIO_IRQ_EN
  logic [1:0]  m_ctrl;
`endif

  bit tx_en;
  int busy;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_status();
    logic [31:0] s;
    s = 32'd0;
    s[0] = (rx_q.size() != 0);
    s[1] = (rx_q.size() == DEPTH);
    s[2] = (tx_q.size() == 0);
    s[3] = (tx_q.size() == DEPTH);
    s[4] = m_rx_ovr;
    s[5] = m_tx_ovr;
    return s;
  endfunction

  function automatic logic m_irq();
`ifdef UART_MMIO_IRQ_EN
    return (m_ctrl[0] && rx_q.size() != 0) || (m_ctrl[1] && tx_q.size() == 0);
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_reset();
    tx_q.delete();
    rx_q.delete();
    din_exp.delete();
    rd_exp.delete();
    m_rx_ovr = 0;
    m_tx_ovr = 0;
`ifdef UART_MMIO_IRQ_EN
    m_ctrl = 2'b00;
`endif
  endtask

  // One bus cycle plus optional dout strobe; the model is advanced at issue.
  task automatic op(input logic w, input logic r, input logic [1:0] a,
                    input logic [31:0] wd, input logic s, input logic [7:0] db);
    logic        full_rx;
    logic        pop;
    logic [31:0] e;
    bus.we = w; bus.re = r; bus.addr = a; bus.wdata = wd;
    bus.dout_rdy = s; bus.dout = db;
    if (r && !w) begin
      case (a)
        2'd0:    e = (rx_q.size() != 0) ? {24'd0, rx_q[0]} : 32'd0;
        2'd1:    e = m_status();
`ifdef UART_MMIO_IRQ_EN
        2'd2:    e = {30'd0, m_ctrl};
`endif
        default: e = 32'd0;
      endcase
      rd_exp.push_back(e);
    end
    full_rx = (rx_q.size() == DEPTH);
    pop = r && !w && (a == 2'd0) && (rx_q.size() != 0);
    if (w) begin
      case (a)
        2'd0: begin
          if (tx_q.size() < DEPTH) begin
            tx_q.push_back(wd[7:0]);
            din_exp.push_back(wd[7:0]);
          end else begin
            m_tx_ovr = 1;
          end
        end
        2'd1: begin
          if (wd[4]) m_rx_ovr = 0;
          if (wd[5]) m_tx_ovr = 0;
        end
`ifdef UART_MMIO_IRQ_EN
        2'd2: m_ctrl = wd[1:0];
`endif
        default: ;
      endcase
    end
    if (pop) void'(rx_q.pop_front());
    if (s) begin
      if (!full_rx || pop) rx_q.push_back(db);
      else m_rx_ovr = 1;
    end
    @(posedge clk); #1;
    bus.we = 0; bus.re = 0; bus.dout_rdy = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic drain();
    tx_en = 1;
    for (int i = 0; i < 3000 && din_exp.size() != 0; i++) idle(1);
    check("tx_drained", din_exp.size(), 0);
    din_exp.delete();
    tx_q.delete();
    idle(15);
  endtask

  // Monitor: compare rdata after each accepted read, din on each strobe.
  initial begin
    forever begin
      logic rd_seen;
      @(posedge clk);
      rd_seen = bus.re && !bus.we && !rst;
      @(negedge clk);
      if (rd_seen) begin
        if (rd_exp.size() == 0) begin
          total++; bad++;
          $display("FAIL rdata_unexpected: got 0x%0h expected no read", bus.rdata);
        end else begin
          check("rdata", bus.rdata, rd_exp.pop_front());
        end
      end
      if (bus.din_rdy) begin
        if (din_exp.size() == 0) begin
          total++; bad++;
          $display("FAIL din_unexpected: got 0x%0h expected no strobe", bus.din);
        end else begin
          check("din", {24'd0, bus.din}, {24'd0, din_exp.pop_front()});
        end
      end
    end
  end

  // UART transmitter model: busy for 10 cycles after each strobe.
  initial begin
    bus.tx_rdy = 1'b0;
    busy = 0;
    forever begin
      @(negedge clk);
      if (bus.din_rdy) busy = 10;
      else if (busy > 0) busy--;
      bus.tx_rdy = tx_en && (busy == 0);
    end
  end

  initial begin
    bus.we = 0; bus.re = 0; bus.addr = 0; bus.wdata = 0;
    bus.dout = 0; bus.dout_rdy = 0;
    tx_en = 0;
    rst = 1;
    model_reset();
    repeat (3) @(posedge clk);
    #3;
    check("rst_rdata", bus.rdata, 0);
    check("rst_din", {24'd0, bus.din}, 0);
    check("rst_din_rdy", {31'd0, bus.din_rdy}, 0);
    check("rst_irq", {31'd0, bus.irq}, 0);
    rst = 0;
    idle(1);

    op(0, 1, 2'd1, 0, 0, 0);                      // STATUS after reset

    // RX path
    op(0, 0, 2'd0, 0, 1, 8'h5A);
    op(0, 0, 2'd0, 0, 1, 8'hA5);
    op(0, 1, 2'd1, 0, 0, 0);
    op(0, 1, 2'd0, 0, 0, 0);
    op(0, 1, 2'd0, 0, 0, 0);
    op(0, 1, 2'd0, 0, 0, 0);
    op(0, 1, 2'd1, 0, 0, 0);

    // TX overflow with transmitter held busy
    for (int i = 0; i < 9; i++) op(1, 0, 2'd0, 32'h10 + i, 0, 0);
    op(0, 1, 2'd1, 0, 0, 0);
    op(1, 0, 2'd1, 32'h20, 0, 0);
    op(0, 1, 2'd1, 0, 0, 0);
    drain();
    op(0, 1, 2'd1, 0, 0, 0);

    // TX path and latency
    op(1, 0, 2'd0, 32'h41, 0, 0);
    check("tx_lat_early", {31'd0, bus.din_rdy}, 0);
    @(posedge clk); #1;
    check("tx_lat", {31'd0, bus.din_rdy}, 1);
    op(1, 0, 2'd0, 32'h42, 0, 0);
    op(1, 0, 2'd0, 32'h43, 0, 0);
    drain();
    op(0, 1, 2'd1, 0, 0, 0);

    // RX overflow, then a strobe concurrent with a pop
    for (int i = 0; i < 9; i++) op(0, 0, 2'd0, 0, 1, 8'h80 + 8'(i));
    op(0, 1, 2'd1, 0, 0, 0);
    op(0, 1, 2'd0, 0, 1, 8'h99);
    op(0, 1, 2'd1, 0, 0, 0);
    for (int i = 0; i < 8; i++) op(0, 1, 2'd0, 0, 0, 0);
    op(1, 0, 2'd1, 32'h10, 0, 0);
    op(0, 1, 2'd1, 0, 0, 0);

    // Interrupt behaviour
`ifdef UART_MMIO_IRQ_EN
    op(1, 0, 2'd2, 32'h1, 0, 0);
    op(0, 0, 2'd0, 0, 1, 8'h33);
    idle(1);
    check("irq_rx", {31'd0, bus.irq}, 1);
    op(0, 1, 2'd0, 0, 0, 0);
    check("irq_hold", {31'd0, bus.irq}, 1);
    idle(1);
    check("irq_rx_clr", {31'd0, bus.irq}, 0);
    op(1, 0, 2'd2, 32'h2, 0, 0);
    idle(1);
    check("irq_tx", {31'd0, bus.irq}, 1);
    op(0, 1, 2'd2, 0, 0, 0);
    op(1, 0, 2'd2, 32'h0, 0, 0);
    idle(1);
    check("irq_off", {31'd0, bus.irq}, 0);
`else
    op(1, 0, 2'd2, 32'h3, 0, 0);
    op(0, 1, 2'd2, 0, 0, 0);
    op(0, 0, 2'd0, 0, 1, 8'h33);
    idle(1);
    check("irq_tied", {31'd0, bus.irq}, 0);
    op(0, 1, 2'd0, 0, 0, 0);
`endif

    // Randomized traffic with the transmitter stalled
    tx_en = 0;
    idle(2);
    for (int n = 0; n < 400; n++) begin
      int unsigned k;
      logic        s;
      logic [7:0]  db;
      logic [1:0]  ra;
      k  = $urandom_range(0, 9);
      s  = ($urandom_range(0, 3) == 0);
      db = 8'($urandom);
      ra = 2'($urandom);
      case (k)
        0, 1:    op(1, 0, 2'd0, $urandom, s, db);
        2, 3:    op(0, 1, 2'd0, 0, s, db);
        4:       op(0, 1, 2'd1, 0, s, db);
        5:       op(1, 0, 2'd1, $urandom, s, db);
        6:       op(1, 0, 2'd2, $urandom, s, db);
        7:       op(0, 1, 2'd2, 0, s, db);
        8:       op($urandom_range(0, 1) == 1, 1'b1, 2'd3, $urandom, s, db);
        default: op(1, 1, ra, $urandom, s, db);
      endcase
      if (n % 25 == 24) begin
        idle(1);
        check("irq_rand", {31'd0, bus.irq}, {31'd0, m_irq()});
      end
    end
    op(0, 1, 2'd1, 0, 0, 0);
    drain();
    op(0, 1, 2'd1, 0, 0, 0);
    op(1, 0, 2'd2, 32'h0, 0, 0);

    // Reset while the FSM is in T_BUSY with 3 bytes still queued
    tx_en = 0;
    idle(2);
    for (int i = 0; i < 4; i++) op(1, 0, 2'd0, 32'hC0 + i, 0, 0);
    tx_en = 1;
    for (int i = 0; i < 40 && din_exp.size() != 3; i++) idle(1);
    check("rst_setup_sent", din_exp.size(), 3);
    #2;
    rst = 1;
    #1;
    check("rst_async_din_rdy", {31'd0, bus.din_rdy}, 0);
    check("rst_async_din", {24'd0, bus.din}, 0);
    check("rst_async_rdata", bus.rdata, 0);
    model_reset();
    @(posedge clk); #3;
    rst = 0;
    idle(1);
    op(0, 1, 2'd1, 0, 0, 0);
    idle(30);
    op(0, 1, 2'd1, 0, 0, 0);
    idle(2);
    check("rd_exp_drained", rd_exp.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
